// File: rtl/sad_frame_sequencer.sv
// Frame sequencer for the SAD vertical processor: fetches image rows, streams the
// template row for each one bit-serially, then samples the processor's match status.
module sad_frame_sequencer #(
   parameter int unsigned IMG_W      = 640,
   parameter int unsigned IMG_H      = 480,
   parameter int unsigned TPL_W      = 40,
   parameter int unsigned TPL_H      = 40,
   parameter int unsigned SETTLE_CYC = 4,
   parameter int unsigned ROW_AW     = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              img_req,
   output logic [ROW_AW-1:0] img_addr,
   input  logic              img_valid,
   input  logic [IMG_W-1:0]  img_data,
   output logic [10:0]       tpl_addr,
   input  logic              tpl_bit,
   output logic [IMG_W-1:0]  original,
   output logic              template,
   output logic              change_row,
   input  logic              sad_status,
   input  logic [9:0]        coordinate,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ROW_AW-1:0] res_row,
   output logic [9:0]        res_col
);

   localparam int unsigned TAW = 11;
   localparam int unsigned CW  = $clog2(TPL_W + 1);
   localparam int unsigned SW  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int unsigned TRW = (TPL_H > 1) ? $clog2(TPL_H) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_STREAM,
      S_SETTLE,
      S_CHECK,
      S_HOLD,
      S_NEXT
   } state_t;

   state_t state_q, state_d;

   logic [ROW_AW-1:0] row_q, row_d;
   logic [TRW-1:0]    tpl_row_q, tpl_row_d;
   logic [TAW-1:0]    tpl_base_q, tpl_base_d;
   logic [CW-1:0]     col_q, col_d;
   logic [SW-1:0]     settle_q, settle_d;

   logic              busy_d, done_d, img_req_d, template_d, change_row_d, res_valid_d;
   logic [ROW_AW-1:0] img_addr_d, res_row_d;
   logic [TAW-1:0]    tpl_addr_d;
   logic [IMG_W-1:0]  original_d;
   logic [9:0]        res_col_d;
   logic              last_row;

   assign last_row = (row_q == ROW_AW'(IMG_H - 1));

   // State and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         row_q      <= '0;
         tpl_row_q  <= '0;
         tpl_base_q <= '0;
         col_q      <= '0;
         settle_q   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         img_req    <= 1'b0;
         img_addr   <= '0;
         tpl_addr   <= '0;
         original   <= '0;
         template   <= 1'b0;
         change_row <= 1'b0;
         res_valid  <= 1'b0;
         res_row    <= '0;
         res_col    <= '0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         tpl_row_q  <= tpl_row_d;
         tpl_base_q <= tpl_base_d;
         col_q      <= col_d;
         settle_q   <= settle_d;
         busy       <= busy_d;
         done       <= done_d;
         img_req    <= img_req_d;
         img_addr   <= img_addr_d;
         tpl_addr   <= tpl_addr_d;
         original   <= original_d;
         template   <= template_d;
         change_row <= change_row_d;
         res_valid  <= res_valid_d;
         res_row    <= res_row_d;
         res_col    <= res_col_d;
      end
   end

   // Next-state and next-output decode; pulses default low, everything else holds
   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      tpl_row_d    = tpl_row_q;
      tpl_base_d   = tpl_base_q;
      col_d        = col_q;
      settle_d     = settle_q;
      busy_d       = busy;
      done_d       = 1'b0;
      img_req_d    = img_req;
      img_addr_d   = img_addr;
      tpl_addr_d   = tpl_addr;
      original_d   = original;
      template_d   = 1'b0;
      change_row_d = 1'b0;
      res_valid_d  = res_valid;
      res_row_d    = res_row;
      res_col_d    = res_col;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_FETCH;
               row_d      = '0;
               tpl_row_d  = '0;
               tpl_base_d = '0;
               busy_d     = 1'b1;
               img_req_d  = 1'b1;
               img_addr_d = '0;
            end
         end
         S_FETCH: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (img_valid) begin
               state_d      = S_STREAM;
               original_d   = img_data;
               img_req_d    = 1'b0;
               change_row_d = 1'b1;
               col_d        = '0;
               tpl_addr_d   = tpl_base_q;
            end
         end
         // ROM data for the address of this cycle is captured into template at the edge
         S_STREAM: begin
            if (col_q == CW'(TPL_W)) begin
               state_d  = S_SETTLE;
               settle_d = '0;
            end else begin
               template_d = tpl_bit;
               col_d      = col_q + CW'(1);
               if (col_q != CW'(TPL_W - 1)) begin
                  tpl_addr_d = tpl_addr + TAW'(1);
               end
            end
         end
         S_SETTLE: begin
            if (settle_q == SW'(SETTLE_CYC - 1)) begin
               state_d = S_CHECK;
            end else begin
               settle_d = settle_q + SW'(1);
            end
         end
         S_CHECK: begin
            if (sad_status) begin
               state_d     = S_HOLD;
               res_valid_d = 1'b1;
               res_row_d   = row_q;
               res_col_d   = coordinate;
            end else begin
               state_d = S_NEXT;
               done_d  = last_row;
            end
         end
         S_HOLD: begin
            if (res_ready) begin
               state_d     = S_NEXT;
               res_valid_d = 1'b0;
               done_d      = last_row;
            end
         end
         // done is already showing here, so a start in this cycle lands outside IDLE
         S_NEXT: begin
            if (last_row) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               state_d    = S_FETCH;
               row_d      = row_q + ROW_AW'(1);
               img_req_d  = 1'b1;
               img_addr_d = row_q + ROW_AW'(1);
               if (tpl_row_q == TRW'(TPL_H - 1)) begin
                  tpl_row_d  = '0;
                  tpl_base_d = '0;
               end else begin
                  tpl_row_d  = tpl_row_q + TRW'(1);
                  tpl_base_d = tpl_base_q + TAW'(TPL_W);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sad_frame_sequencer.sv
// Randomized bench for sad_frame_sequencer: row memory, template ROM, processor and
// result sink models, checked against per-frame expectations built from the row rules.
module tb_sad_frame_sequencer;

   localparam int unsigned IMG_W      = 640;
   localparam int unsigned IMG_H      = 48;
   localparam int unsigned TPL_W      = 40;
   localparam int unsigned TPL_H      = 40;
   localparam int unsigned SETTLE_CYC = 4;
   localparam int unsigned ROW_AW     = 10;
   localparam int          LIMIT      = 6000;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              busy, done, img_req;
   logic [ROW_AW-1:0] img_addr;
   logic              img_valid;
   logic [IMG_W-1:0]  img_data;
   logic [10:0]       tpl_addr;
   logic              tpl_bit;
   logic [IMG_W-1:0]  original;
   logic              template, change_row;
   logic              sad_status;
   logic [9:0]        coordinate;
   logic              res_valid, res_ready;
   logic [ROW_AW-1:0] res_row;
   logic [9:0]        res_col;

   logic [TPL_H*TPL_W-1:0] rom_v;
   logic [IMG_W-1:0]       mem [IMG_H];
   bit                     match [IMG_H];
   int                     coord [IMG_H];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Template ROM: data follows the address within the cycle, template registers it
   assign tpl_bit = rom_v[tpl_addr];

   sad_frame_sequencer #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .TPL_W(TPL_W), .TPL_H(TPL_H),
      .SETTLE_CYC(SETTLE_CYC), .ROW_AW(ROW_AW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .img_req(img_req), .img_addr(img_addr), .img_valid(img_valid), .img_data(img_data),
      .tpl_addr(tpl_addr), .tpl_bit(tpl_bit), .original(original), .template(template),
      .change_row(change_row), .sad_status(sad_status), .coordinate(coordinate),
      .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row), .res_col(res_col)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] out_zero();
      return {busy, done, img_req, change_row, template, res_valid,
              |img_addr, |tpl_addr, |original, |res_row, |res_col};
   endfunction

   task automatic setup(input int rom_mode, input int match_pct);
      for (int i = 0; i < TPL_H*TPL_W; i++)
         rom_v[i] = (rom_mode == 0) ? 1'((i % TPL_W) % 2) : 1'($urandom % 2);
      for (int r = 0; r < IMG_H; r++) begin
         for (int k = 0; k < IMG_W/32; k++) mem[r][k*32 +: 32] = $urandom;
         match[r] = (($urandom % 100) < match_pct);
         coord[r] = $urandom % IMG_W;
      end
   endtask

   task automatic do_reset();
      #2 rst = 1'b0;
      #1 check("rst_clear", 64'(out_zero()), 0);
      start = 1'b0; img_valid = 1'b0; res_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("no_done_in_rst", done, 0);
      end
      rst = 1'b1;
   endtask

   // One frame: lat = cycles from img_req rising to img_valid, rdy_wait = cycles res_ready stays low
   task automatic run_frame(input int lat, input int rdy_wait, input bit stray,
                            input int abort_row, input bit mid_start);
      int cyc = 0, req_n = 0, load_n = 0, cur = 0, req_len = 0, vcnt = 0;
      int win = 0, hold_n = 0, hs_cyc = -10, mi = 0;
      bit req_prev = 0, rv_prev = 0, hs_pend = 0, fin = 0, post = 0;
      logic [TPL_W-1:0]    tv, te;
      logic [ROW_AW+9:0]   held = '0;
      int exp_row[$];
      int exp_col[$];
      tv = '0;
      for (int r = 0; r < IMG_H; r++)
         if (match[r]) begin
            exp_row.push_back(r);
            exp_col.push_back(coord[r]);
         end
      while (!fin) begin
         @(negedge clk);
         cyc++;
         if (post) begin
            check("busy_after_done", busy, 0);
            check("done_width", done, 0);
            check("start_at_done_ignored", img_req, 0);
            start = 1'b0;
            fin = 1;
         end else begin
            if (cyc == 2) check("busy_start", busy, 1);
            if (img_req && !req_prev) begin
               check("img_addr", img_addr, req_n);
               cur = req_n; req_n++; req_len = 0; vcnt = 0;
            end
            if (img_req) req_len++;
            if (!img_req && req_prev) check("req_len", req_len, lat + 1);
            req_prev = img_req;
            if (hs_pend) begin
               check("rv_drop", res_valid, 0);
               hs_pend = 0;
            end
            if (change_row) begin
               load_n++;
               check("one_load", load_n, req_n);
               check("original", original == mem[cur], 1);
               check("tpl_base", tpl_addr, (cur % TPL_H) * TPL_W);
               win = 1;
            end else if (win > 0 && win <= TPL_W) begin
               tv[win-1] = template;
               win++;
            end else if (win == TPL_W + 1) begin
               for (int c = 0; c < TPL_W; c++) te[c] = rom_v[(cur % TPL_H) * TPL_W + c];
               check("template", tv, te);
               check("tpl_idle", template, 0);
               check("orig_hold", original == mem[cur], 1);
               win = 0;
            end
            if (res_valid) begin
               check("req_in_hold", img_req, 0);
               if (!rv_prev) begin
                  if (mi < exp_row.size())
                     check("res_payload", {res_row, res_col},
                           {ROW_AW'(exp_row[mi]), 10'(exp_col[mi])});
                  else
                     check("res_extra", 1, 0);
                  held = {res_row, res_col};
                  mi++;
                  hold_n = 0;
               end else begin
                  check("res_stable", {res_row, res_col}, held);
               end
            end
            rv_prev = res_valid;
            if (done) begin
               check("rows_req", req_n, IMG_H);
               check("rows_loaded", load_n, IMG_H);
               check("results", mi, exp_row.size());
               if (match[IMG_H-1]) check("done_after_hs", cyc, hs_cyc + 1);
               post = 1;
            end
            if (cyc > LIMIT) begin
               check("timeout", 0, 1);
               rst = 1'b0;
               @(negedge clk);
               rst = 1'b1;
               fin = 1;
            end else if (abort_row >= 0 && load_n == abort_row + 1 && win == 10) begin
               do_reset();
               fin = 1;
            end else begin
               start = (cyc == 1) || (mid_start && cyc == 60) || done;
               img_valid = 1'b0;
               if (img_req) begin
                  if (vcnt == lat) begin
                     img_valid = 1'b1;
                     img_data  = mem[img_addr];
                  end
                  vcnt++;
               end
               if (stray && win == 5) begin
                  img_valid = 1'b1;
                  img_data  = ~mem[cur];
               end
               sad_status = match[cur];
               coordinate = 10'(coord[cur]);
               if (res_valid) begin
                  if (hold_n >= rdy_wait) begin
                     res_ready = 1'b1;
                     hs_cyc    = cyc;
                     hs_pend   = 1;
                  end else begin
                     res_ready = 1'b0;
                  end
                  hold_n++;
               end else begin
                  res_ready = 1'($urandom % 2);
               end
            end
         end
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; img_valid = 1'b0; img_data = '0;
      sad_status = 1'b0; coordinate = '0; res_ready = 1'b0;
      rom_v = '0;
      #12;
      check("reset_state", 64'(out_zero()), 0);
      @(negedge clk);
      rst = 1'b1;
      // alternating template, no matches
      setup(0, 0);
      run_frame(2, 0, 0, -1, 0);
      // match on row 5 at column 123 with a 7-cycle stall
      setup(1, 15);
      match[5] = 1'b1;
      coord[5] = 123;
      run_frame(3, 7, 0, -1, 0);
      // slow memory plus a stray img_valid mid-stream
      setup(1, 10);
      run_frame(9, 2, 1, -1, 0);
      // extra start mid-frame, then reset during row 2
      setup(1, 50);
      run_frame(2, 1, 0, 2, 1);
      // fresh frame after reset; last row matches and is accepted immediately
      setup(0, 20);
      match[IMG_H-1] = 1'b1;
      run_frame(1, 0, 0, -1, 0);
      setup(1, 30);
      run_frame(1 + int'($urandom % 4), int'($urandom % 5), 1, -1, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
